raster_block_address: RTL and testbench

Raster-order pixel-to-block address generator for the VGA pixel path. It replaces the combinational shift-based block lookup with exact, parameterised block dimensions, including non-power-of-two sizes such as the intended 10×10. Block coordinates are tracked incrementally from pixel/line/frame strobes, so no divider or multiplier is needed. It sits between the VGA timing generator and the block-attribute RAM, and presents one registered RAM address per active pixel with a valid flag and an in-range flag.

---
 rtl/raster_block_address.sv | 119 +++++++++++
 tb/tb_raster_block_address.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/raster_block_address.sv
// Raster pixel -> block RAM address generator with exact (non-power-of-two) block sizes.
// Latency 1 cycle: outputs register the block state of the pixel accepted on the previous edge.
// No backpressure: a pixel is taken whenever pix_valid=1; idle cycles hold state and drop addr_valid.
module raster_block_address #(
  parameter int BLK_W    = 10,
  parameter int BLK_H    = 10,
  parameter int BLOCKS_X = 64,
  parameter int BLOCKS_Y = 48,
  parameter int ADDR_W   = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pix_valid,
  input  logic                              frame_start,
  input  logic                              line_start,
  output logic [ADDR_W-1:0]                 address,
  output logic [$clog2(BLOCKS_X+1)-1:0]     block_x,
  output logic [$clog2(BLOCKS_Y+1)-1:0]     block_y,
  output logic                              addr_valid,
  output logic                              in_range,
  output logic                              block_first
);

  localparam int SX_W = $clog2(BLK_W + 1);
  localparam int SY_W = $clog2(BLK_H + 1);
  localparam int BX_W = $clog2(BLOCKS_X + 1);
  localparam int BY_W = $clog2(BLOCKS_Y + 1);

  localparam logic [SX_W-1:0]   SX_LAST   = SX_W'(BLK_W - 1);
  localparam logic [SY_W-1:0]   SY_LAST   = SY_W'(BLK_H - 1);
  localparam logic [BX_W-1:0]   BX_LIMIT  = BX_W'(BLOCKS_X);
  localparam logic [BY_W-1:0]   BY_LIMIT  = BY_W'(BLOCKS_Y);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(BLOCKS_X);

  logic [SX_W-1:0]   sub_x, n_sub_x;
  logic [SY_W-1:0]   sub_y, n_sub_y;
  logic [BX_W-1:0]   blk_x, n_blk_x;
  logic [BY_W-1:0]   blk_y, n_blk_y;
  logic [ADDR_W-1:0] row_base, n_row_base;
  logic              synced;

  logic              accept;
  logic              n_in_range;
  logic [ADDR_W-1:0] n_address;

  // Before the first frame_start the counters have no meaning, so only frame_start is taken.
  assign accept = pix_valid && (frame_start || synced);

  always_comb begin
    n_sub_x    = sub_x;
    n_sub_y    = sub_y;
    n_blk_x    = blk_x;
    n_blk_y    = blk_y;
    n_row_base = row_base;
    if (frame_start) begin
      n_sub_x    = '0;
      n_sub_y    = '0;
      n_blk_x    = '0;
      n_blk_y    = '0;
      n_row_base = '0;
    end else if (line_start) begin
      n_sub_x = '0;
      n_blk_x = '0;
      if (sub_y == SY_LAST) begin
        n_sub_y = '0;
        // row_base freezes once blk_y saturates below the RAM
        if (blk_y < BY_LIMIT) begin
          n_blk_y    = blk_y + 1'b1;
          n_row_base = row_base + ROW_STEP;
        end
      end else begin
        n_sub_y = sub_y + 1'b1;
      end
    end else if (blk_x < BX_LIMIT) begin
      if (sub_x == SX_LAST) begin
        n_sub_x = '0;
        n_blk_x = blk_x + 1'b1;
      end else begin
        n_sub_x = sub_x + 1'b1;
      end
    end
  end

  assign n_in_range = (n_blk_x < BX_LIMIT) && (n_blk_y < BY_LIMIT);
  assign n_address  = n_in_range ? (n_row_base + ADDR_W'(n_blk_x)) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_x       <= '0;
      sub_y       <= '0;
      blk_x       <= '0;
      blk_y       <= '0;
      row_base    <= '0;
      synced      <= 1'b0;
      address     <= '0;
      block_x     <= '0;
      block_y     <= '0;
      addr_valid  <= 1'b0;
      in_range    <= 1'b0;
      block_first <= 1'b0;
    end else begin
      addr_valid <= accept;
      if (accept) begin
        sub_x       <= n_sub_x;
        sub_y       <= n_sub_y;
        blk_x       <= n_blk_x;
        blk_y       <= n_blk_y;
        row_base    <= n_row_base;
        synced      <= 1'b1;
        address     <= n_address;
        block_x     <= n_blk_x;
        block_y     <= n_blk_y;
        in_range    <= n_in_range;
        block_first <= (n_sub_x == '0) && (n_sub_y == '0);
      end
    end
  end

endmodule

// File: tb/tb_raster_block_address.sv
// Directed bench for raster_block_address: 10x10 blocks on the main instance, 16x16 blocks on a second.
module tb_raster_block_address;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic        frame_start;
  logic        line_start;

  logic [11:0] address;
  logic [6:0]  block_x;
  logic [5:0]  block_y;
  logic        addr_valid;
  logic        in_range;
  logic        block_first;

  logic [11:0] address16;
  logic [6:0]  block_x16;
  logic [5:0]  block_y16;
  logic        addr_valid16;
  logic        in_range16;
  logic        block_first16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  raster_block_address dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid),
    .frame_start(frame_start), .line_start(line_start),
    .address(address), .block_x(block_x), .block_y(block_y),
    .addr_valid(addr_valid), .in_range(in_range), .block_first(block_first)
  );

  raster_block_address #(.BLK_W(16), .BLK_H(16)) dut16 (
    .clk(clk), .reset(reset), .pix_valid(pix_valid),
    .frame_start(frame_start), .line_start(line_start),
    .address(address16), .block_x(block_x16), .block_y(block_y16),
    .addr_valid(addr_valid16), .in_range(in_range16), .block_first(block_first16)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one pixel; returns #1 after the edge that accepted it, inputs still held.
  task automatic px(input logic fs, input logic ls);
    @(negedge clk);
    pix_valid   = 1'b1;
    frame_start = fs;
    line_start  = ls;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_valid   = 1'b0;
      frame_start = 1'b0;
      line_start  = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gx, gy;
    reset = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; line_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_address", 32'(address), 0);
    chk("rst_block_x", 32'(block_x), 0);
    chk("rst_block_y", 32'(block_y), 0);
    chk("rst_addr_valid", 32'(addr_valid), 0);
    chk("rst_in_range", 32'(in_range), 0);
    chk("rst_block_first", 32'(block_first), 0);
    @(negedge clk);
    reset = 1'b0;

    // Pixels and line starts before any frame_start are ignored.
    px(0, 0); chk("unsync_px0", 32'(addr_valid), 0);
    px(0, 1); chk("unsync_ls", 32'(addr_valid), 0);
    px(0, 0); chk("unsync_px1", 32'(addr_valid), 0);

    // 25 pixels from frame_start: blocks 0,0..0 / 1.. / 2..
    for (int i = 0; i < 25; i++) begin
      px(i == 0, 0);
      chk("run25_address", 32'(address), i / 10);
      chk("run25_first", 32'(block_first), (i % 10 == 0) ? 1 : 0);
      chk("run25_valid", 32'(addr_valid), 1);
    end
    idle(1);
    chk("gap_valid", 32'(addr_valid), 0);
    chk("gap_hold_address", 32'(address), 2);

    // Line 0 is 641 pixels long to overrun the RAM width; lines 1..11 are 640.
    for (int ln = 0; ln < 12; ln++) begin
      for (int x = 0; x < ((ln == 0) ? 641 : 640); x++) begin
        px(ln == 0 && x == 0, ln != 0 && x == 0);
        if (ln == 0 && x == 639) begin
          chk("x639_address", 32'(address), 63);
          chk("x639_in_range", 32'(in_range), 1);
        end
        if (ln == 0 && x == 640) begin
          chk("x640_in_range", 32'(in_range), 0);
          chk("x640_address", 32'(address), 0);
          chk("x640_block_x", 32'(block_x), 64);
          chk("x640_valid", 32'(addr_valid), 1);
        end
        if (ln == 9 && x == 639) chk("l9_last_address", 32'(address), 63);
        if (ln == 10 && x == 0) begin
          chk("l10_first_address", 32'(address), 64);
          chk("l10_block_first", 32'(block_first), 1);
        end
        if (ln == 11 && x == 0) begin
          chk("l11_first_address", 32'(address), 64);
          chk("l11_block_first", 32'(block_first), 0);
        end
      end
    end

    // 481 lines of one pixel each to walk blk_y off the bottom of the RAM.
    px(1, 0);
    for (int ln = 1; ln < 482; ln++) begin
      px(0, 1);
      if (ln == 479) begin
        chk("l479_block_y", 32'(block_y), 47);
        chk("l479_in_range", 32'(in_range), 1);
        chk("l479_address", 32'(address), 47 * 64);
      end
      if (ln == 480) begin
        chk("l480_block_y", 32'(block_y), 48);
        chk("l480_in_range", 32'(in_range), 0);
        chk("l480_address", 32'(address), 0);
      end
      if (ln == 481) chk("l481_block_y_sat", 32'(block_y), 48);
    end
    // frame_start together with line_start behaves as frame_start.
    px(1, 1);
    chk("refs_address", 32'(address), 0);
    chk("refs_block_y", 32'(block_y), 0);
    chk("refs_in_range", 32'(in_range), 1);
    chk("refs_block_first", 32'(block_first), 1);

    // Mid-frame frame_start restarts at (0,0).
    for (int i = 0; i < 14; i++) px(0, 0);
    chk("mid_address", 32'(address), 1);
    px(1, 0);
    chk("mid_fs_address", 32'(address), 0);
    chk("mid_fs_first", 32'(block_first), 1);

    // Asynchronous reset mid-line with pix_valid held high.
    for (int i = 0; i < 12; i++) px(0, 0);
    chk("pre_rst_address", 32'(address), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_address", 32'(address), 0);
    chk("async_rst_valid", 32'(addr_valid), 0);
    chk("async_rst_block_x", 32'(block_x), 0);
    @(negedge clk);
    reset = 1'b0;
    px(0, 0); chk("post_rst_px", 32'(addr_valid), 0);
    px(0, 1); chk("post_rst_ls", 32'(addr_valid), 0);
    px(1, 0);
    chk("post_rst_fs_valid", 32'(addr_valid), 1);
    chk("post_rst_fs_address", 32'(address), 0);

    // 16x16 instance: 40 lines of 640 with random idle gaps between pixels.
    for (gy = 0; gy < 40; gy++) begin
      for (gx = 0; gx < 640; gx++) begin
        px(gy == 0 && gx == 0, gy != 0 && gx == 0);
        chk("b16_address", 32'(address16), (gy >> 4) * 64 + (gx >> 4));
        chk("b16_valid", 32'(addr_valid16), 1);
        if ($urandom_range(0, 15) == 0) begin
          idle($urandom_range(1, 3));
          chk("b16_gap_valid", 32'(addr_valid16), 0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
